// File: rtl/register_pipeline_pkg.sv
// Shared constants and helpers for the register_pipeline delay line.
// The FILLED counter width helper serves the REGISTER_PIPELINE_FILL_STATUS_EN build.
package register_pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_STAGES = 8;

    // Bits needed to count 0..n inclusive, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n) + 64'd1) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/register_pipeline_if.sv
// Data/enable bundle for register_pipeline. The FILLED signal exists only
// when REGISTER_PIPELINE_FILL_STATUS_EN is defined.
interface register_pipeline_if
    import register_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  CE;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
`ifdef REGISTER_PIPELINE_FILL_STATUS_EN
    logic                  FILLED;

    modport master (output CE, output DATA_IN, input DATA_OUT, input FILLED);
    modport slave  (input CE, input DATA_IN, output DATA_OUT, output FILLED);
`else
    modport master (output CE, output DATA_IN, input DATA_OUT);
    modport slave  (input CE, input DATA_IN, output DATA_OUT);
`endif
endinterface

// File: rtl/register_pipeline_stage.sv
// One delay-line register: synchronous active-low reset to RESET_VALUE,
// load on CE, hold otherwise.
module pipeline_stage #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= RESET_VALUE;
        end else if (ce) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_pipeline.sv
// Clock-enabled shift-register delay line of NUM_STAGES registers.
// Define REGISTER_PIPELINE_FILL_STATUS_EN to add the FILLED status output.
module register_pipeline
    import register_pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int                    NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                CLK,
    input logic                RSTN,
    register_pipeline_if.slave bus
);

    genvar gi;

    generate
        if (NUM_STAGES == 0) begin : g_pass
            // Zero stages degenerates to a wire; clock, reset and enable are unused.
            assign bus.DATA_OUT = bus.DATA_IN;
`ifdef REGISTER_PIPELINE_FILL_STATUS_EN
            assign bus.FILLED = 1'b1;
`endif
        end else begin : g_regs
            logic [DATA_WIDTH-1:0] stage_q [NUM_STAGES];

            for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
                logic [DATA_WIDTH-1:0] stage_d;

                if (gi == 0) begin : g_first
                    assign stage_d = bus.DATA_IN;
                end else begin : g_rest
                    assign stage_d = stage_q[gi-1];
                end

                pipeline_stage #(
                    .DATA_WIDTH  (DATA_WIDTH),
                    .RESET_VALUE (RESET_VALUE)
                ) u_stage (
                    .clk   (CLK),
                    .rst_n (RSTN),
                    .ce    (bus.CE),
                    .d     (stage_d),
                    .q     (stage_q[gi])
                );
            end

            assign bus.DATA_OUT = stage_q[NUM_STAGES-1];

`ifdef REGISTER_PIPELINE_FILL_STATUS_EN
            localparam int            CW   = cnt_width(NUM_STAGES);
            localparam logic [CW-1:0] FULL = CW'(NUM_STAGES);

            logic [CW-1:0] fill_cnt_reg;
            logic [CW-1:0] fill_cnt_next;

            // Counts enabled edges since reset; once it reaches the depth, the
            // last stage no longer holds a reset value.
            always_comb begin
                fill_cnt_next = fill_cnt_reg;
                if (bus.CE && (fill_cnt_reg != FULL)) begin
                    fill_cnt_next = fill_cnt_reg + CW'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    fill_cnt_reg <= '0;
                end else begin
                    fill_cnt_reg <= fill_cnt_next;
                end
            end

            assign bus.FILLED = (fill_cnt_reg == FULL);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_register_pipeline.sv
// Randomized bench for register_pipeline against a sample-history model.
// Covers 8-stage, 0-stage, 1-stage/1-bit and non-zero reset-value builds.
module tb_register_pipeline;

    logic clk;
    logic rstn;

    int check_cnt;
    int err_cnt;

    // Values accepted on enabled edges since the last reset, newest last.
    logic [15:0] hist[$];
    int          accepted;

    register_pipeline_if #(.DATA_WIDTH(16)) bus0 ();
    register_pipeline_if #(.DATA_WIDTH(16)) bus1 ();
    register_pipeline_if #(.DATA_WIDTH(1))  bus2 ();
    register_pipeline_if #(.DATA_WIDTH(16)) bus3 ();

    register_pipeline #(.DATA_WIDTH(16), .NUM_STAGES(8), .RESET_VALUE(16'h0000))
        dut_main (.CLK(clk), .RSTN(rstn), .bus(bus0));
    register_pipeline #(.DATA_WIDTH(16), .NUM_STAGES(0), .RESET_VALUE(16'h0000))
        dut_pass (.CLK(clk), .RSTN(rstn), .bus(bus1));
    register_pipeline #(.DATA_WIDTH(1), .NUM_STAGES(1), .RESET_VALUE(1'b0))
        dut_one (.CLK(clk), .RSTN(rstn), .bus(bus2));
    register_pipeline #(.DATA_WIDTH(16), .NUM_STAGES(8), .RESET_VALUE(16'h5A5A))
        dut_rv (.CLK(clk), .RSTN(rstn), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output of an n-deep line: the sample accepted n enabled edges ago, else reset value.
    function automatic logic [15:0] expect_out(input int n, input logic [15:0] rv);
        if (hist.size() >= n) begin
            return hist[hist.size() - n];
        end
        return rv;
    endfunction

    // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic do_cycle(input logic r, input logic ce, input logic [15:0] din, input string tag);
        logic [15:0] e0;
        logic [15:0] e3;
        logic [15:0] e2w;
        rstn          = r;
        bus0.CE       = ce;
        bus1.CE       = ce;
        bus2.CE       = ce;
        bus3.CE       = ce;
        bus0.DATA_IN  = din;
        bus1.DATA_IN  = din;
        bus2.DATA_IN  = din[0];
        bus3.DATA_IN  = din;
        #1;
        check({tag, "_pass"}, 32'(bus1.DATA_OUT), 32'(din));
        @(posedge clk);
        if (!r) begin
            hist.delete();
            accepted = 0;
        end else if (ce) begin
            hist.push_back(din);
            accepted++;
            if (hist.size() > 8) void'(hist.pop_front());
        end
        @(negedge clk);
        e0  = expect_out(8, 16'h0000);
        e3  = expect_out(8, 16'h5A5A);
        e2w = expect_out(1, 16'h0000);
        check({tag, "_main"}, 32'(bus0.DATA_OUT), 32'(e0));
        check({tag, "_rv"},   32'(bus3.DATA_OUT), 32'(e3));
        check({tag, "_one"},  32'(bus2.DATA_OUT), 32'(e2w[0]));
`ifdef REGISTER_PIPELINE_FILL_STATUS_EN
        check({tag, "_filled"},      32'(bus0.FILLED), 32'(accepted >= 8));
        check({tag, "_filled_pass"}, 32'(bus1.FILLED), 32'd1);
`endif
    endtask

    initial begin
        logic [15:0] v;
        check_cnt = 0;
        err_cnt   = 0;
        accepted  = 0;
        rstn      = 1'b0;
        bus0.CE = 1'b0; bus1.CE = 1'b0; bus2.CE = 1'b0; bus3.CE = 1'b0;
        bus0.DATA_IN = '0; bus1.DATA_IN = '0; bus2.DATA_IN = '0; bus3.DATA_IN = '0;
        @(negedge clk);

        // Reset held with all-ones input; enable randomized to show it is ignored.
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'($urandom), 16'hFFFF, "reset");
        do_cycle(1'b1, 1'b0, 16'hFFFF, "release");

        // Latency with continuous enable, then hold the last input.
        do_cycle(1'b1, 1'b1, 16'hA5A5, "lat");
        do_cycle(1'b1, 1'b1, 16'h1234, "lat");
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, 16'($urandom), "lat");
        v = 16'($urandom);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, v, "settle");

        // Stall: load a counting sequence, freeze, then resume.
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b1, 16'(i), "load");
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 16'($urandom), "stall");
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1, 16'($urandom), "resume");

        // Reset while full of BEEF, then refill with gaps in the enable.
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1, 16'hBEEF, "beef");
        do_cycle(1'b0, 1'b1, 16'hBEEF, "midrst");
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 1'b1, 16'($urandom), "refill");
            if (i == 2 || i == 4 || i == 6) do_cycle(1'b1, 1'b0, 16'($urandom), "gap");
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 16'($urandom), "hold");

        // Random mix of enable, data and occasional resets.
        for (int i = 0; i < 300; i++) begin
            do_cycle(($urandom_range(0, 19) != 0), 1'($urandom), 16'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
